// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the RV32M multiply/divide unit.
//   op_e    : funct3 operation codes (MUL..REMU)
//   state_e : control FSM states
//   is_div / op_signed_a / op_signed_b : operation decode helpers
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_div(input op_e op);
        return op[2];
    endfunction

    // SrcA is treated as signed for every signed flavour, including MULHSU.
    function automatic logic op_signed_a(input op_e op);
        return (op == MUL) || (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic op_signed_b(input op_e op);
        return (op == MUL) || (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and muldiv_unit.
//   start, Operation, SrcA, SrcB : request (master -> slave)
//   busy, done, Result           : status/response (slave -> master)
interface muldiv_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
);
    logic                     start;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic                     busy;
    logic                     done;
    logic [DATA_WIDTH-1:0]    Result;

    modport master (output start, Operation, SrcA, SrcB, input  busy, done, Result);
    modport slave  (input  start, Operation, SrcA, SrcB, output busy, done, Result);
endinterface

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-division iteration.
//   part_i    : shifted partial remainder {rem, next dividend bit}
//   divisor_i : unsigned divisor magnitude
//   rem_o     : next partial remainder
//   q_o       : quotient bit produced by this iteration
module muldiv_div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH:0]   part_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic                  q_o
);
    logic [DATA_WIDTH:0] diff;

    // part_i < 2*divisor always holds, so the MSB of the difference is a
    // clean borrow flag: clear means part_i >= divisor.
    assign diff  = part_i - {1'b0, divisor_i};
    assign q_o   = ~diff[DATA_WIDTH];
    assign rem_o = q_o ? diff[DATA_WIDTH-1:0] : part_i[DATA_WIDTH-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (radix-2 shift-add multiply,
// restoring divide), one operation per start/done handshake.
//   clk, reset : clock, synchronous active-high reset
//   bus        : muldiv_if slave (start/Operation/SrcA/SrcB in, busy/done/Result out)
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// combinational product instead of the iterative datapath.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 3
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*W-1:0]    acc_q, acc_d;    // mul: {hi, multiplier}; div: {rem, dividend/quotient}
    logic [W-1:0]      opnd_q, opnd_d;  // multiplicand or divisor magnitude
    logic [W-1:0]      res_q, res_d;
    logic              neg_q, neg_d;    // sign of the selected result

    // ---- request decode ----
    op_e          op_in;
    logic         a_neg, b_neg, div_zero, div_ovf;
    logic [W-1:0] a_abs, b_abs;

    assign op_in    = op_e'(bus.Operation[2:0]);
    assign a_neg    = op_signed_a(op_in) & bus.SrcA[W-1];
    assign b_neg    = op_signed_b(op_in) & bus.SrcB[W-1];
    assign a_abs    = a_neg ? -bus.SrcA : bus.SrcA;
    assign b_abs    = b_neg ? -bus.SrcB : bus.SrcB;
    assign div_zero = is_div(op_in) && (bus.SrcB == '0);
    assign div_ovf  = is_div(op_in) && op_signed_b(op_in) &&
                      (bus.SrcA == MIN_VAL) && (bus.SrcB == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fast_mag, fast_prod;
    logic [W-1:0]   fast_res;
    assign fast_mag  = {{W{1'b0}}, a_abs} * {{W{1'b0}}, b_abs};
    assign fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
    assign fast_res  = (op_in == MUL) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
`endif

    // ---- one iteration of the selected datapath ----
    logic [W:0]     mul_sum;
    logic [2*W-1:0] step_acc;
    logic [W-1:0]   div_rem;
    logic           div_q;

    assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

    muldiv_div_step #(.DATA_WIDTH(W)) u_div_step (
        .part_i    ({acc_q[2*W-1:W], acc_q[W-1]}),
        .divisor_i (opnd_q),
        .rem_o     (div_rem),
        .q_o       (div_q)
    );

    assign step_acc = is_div(op_q) ? {div_rem, acc_q[W-2:0], div_q}
                                   : {mul_sum, acc_q[W-1:1]};

    // ---- sign correction and result selection on the last iteration ----
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quo_s, rem_s, fin_res;

    always_comb begin
        prod_s = neg_q ? -step_acc : step_acc;
        quo_s  = neg_q ? -step_acc[W-1:0] : step_acc[W-1:0];
        rem_s  = neg_q ? -step_acc[2*W-1:W] : step_acc[2*W-1:W];
        case (op_q)
            MUL:                 fin_res = prod_s[W-1:0];
            MULH, MULHSU, MULHU: fin_res = prod_s[2*W-1:W];
            DIV, DIVU:           fin_res = quo_s;
            default:             fin_res = rem_s;
        endcase
    end

    // ---- FSM ----
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    op_d  = op_in;
                    // remainder takes the dividend's sign; everything else a^b
                    neg_d = (is_div(op_in) && op_in[1]) ? a_neg : (a_neg ^ b_neg);
                    if (div_zero) begin
                        res_d   = op_in[1] ? bus.SrcA : '1;
                        state_d = DONE;
                    end else if (div_ovf) begin
                        res_d   = op_in[1] ? '0 : bus.SrcA;
                        state_d = DONE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!is_div(op_in)) begin
                        res_d   = fast_res;
                        state_d = DONE;
`endif
                    end else begin
                        cnt_d   = CW'(W-1);
                        state_d = CALC;
                        acc_d   = {{W{1'b0}}, is_div(op_in) ? a_abs : b_abs};
                        opnd_d  = is_div(op_in) ? b_abs : a_abs;
                    end
                end
            end
            CALC: begin
                acc_d = step_acc;
                if (cnt_q == '0) begin
                    res_d   = fin_res;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= MUL;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.busy   = (state_q == CALC);
    assign bus.done   = (state_q == DONE);
    assign bus.Result = res_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: self-checking bench for muldiv_unit (DATA_WIDTH=32).
// Expected results come from a 64-bit arithmetic reference model; latency,
// busy-cycle count, result stability and done pulse shape are checked per op.
// Honors MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    muldiv_if #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) bus ();

    muldiv_unit #(.DATA_WIDTH(W), .OPCODE_LENGTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit / 32-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          qi;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                qi = $signed(a) / $signed(b);
                return 32'(qi);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                qi = $signed(a) % $signed(b);
                return 32'(qi);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return W + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // Issue one op at the current time; returns during the done cycle.
    // With hold=1, start stays high and operands/op are scrambled while busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input string tag);
        logic [31:0] exp_r, res0;
        int          lat, nbusy, elat;
        bit          moved;
        exp_r = ref_model(op, a, b);
        elat  = exp_latency(op, a, b);
        res0  = bus.Result;
        moved = 0;
        nbusy = 0;
        bus.start     = 1'b1;
        bus.Operation = op;
        bus.SrcA      = a;
        bus.SrcB      = b;
        tick();
        lat = 1;
        if (!hold) bus.start = 1'b0;
        while (!bus.done && lat < 100) begin
            if (bus.busy) nbusy++;
            if (bus.Result !== res0) moved = 1;
            if (hold) begin
                bus.Operation = 3'($urandom);
                bus.SrcA      = $urandom;
                bus.SrcB      = $urandom;
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".busy_cycles"}, 32'(nbusy), 32'(elat - 1));
        check({tag, ".result_stable"}, {31'b0, moved}, 32'h0);
        check({tag, ".result"}, bus.Result, exp_r);
    endtask

    task automatic done_drops(input string tag);
        tick();
        check({tag, ".done_pulse"}, {31'b0, bus.done}, 32'h0);
    endtask

    initial begin
        int ndone;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.Operation = 3'd0;
        bus.SrcA      = '0;
        bus.SrcB      = '0;
        tick();
        tick();
        check("reset.busy", {31'b0, bus.busy}, 32'h0);
        check("reset.done", {31'b0, bus.done}, 32'h0);
        check("reset.result", bus.Result, 32'h0);
        reset = 1'b0;
        tick();

        // directed cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul_7_m3");          done_drops("mul_7_m3");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");     done_drops("mulhu");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh");      done_drops("mulh");
        run_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 0, "mulhsu");    done_drops("mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");          done_drops("div_m7_2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem_m7_2");          done_drops("rem_m7_2");
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 0, "divu_m7_2");         done_drops("divu_m7_2");
        run_op(3'd7, 32'hFFFF_FFF9, 32'd2, 0, "remu_m7_2");         done_drops("remu_m7_2");
        run_op(3'd4, 32'd5, 32'd0, 0, "div_by_zero");               done_drops("div_by_zero");
        run_op(3'd6, 32'd5, 32'd0, 0, "rem_by_zero");               done_drops("rem_by_zero");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");   done_drops("div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");   done_drops("rem_ovf");

        // start held high during a divide with scrambled inputs
        run_op(3'd4, 32'd1000, 32'hFFFF_FFF9, 1, "div_hold");       done_drops("div_hold");

        // back-to-back: second start issued in the done cycle of the first
        run_op(3'd5, 32'd100, 32'd7, 0, "b2b_first");
        run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 0, "b2b_second");        done_drops("b2b_second");

        // reset in cycle 10 of a divide
        bus.start     = 1'b1;
        bus.Operation = 3'd4;
        bus.SrcA      = 32'd12345;
        bus.SrcB      = 32'd17;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort.busy", {31'b0, bus.busy}, 32'h0);
        check("abort.done", {31'b0, bus.done}, 32'h0);
        check("abort.result", bus.Result, 32'h0);
        ndone = 0;
        repeat (40) begin
            if (bus.done) ndone++;
            tick();
        end
        check("abort.no_done", 32'(ndone), 32'h0);
        run_op(3'd4, 32'd12345, 32'd17, 0, "after_abort");          done_drops("after_abort");

        // randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), pick(), pick(), 0, $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 0) done_drops($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
